// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared constants for the calculator operation sequencer:
//            button_cclt opcode values, execution-unit indices and the
//            sequencer FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Opcodes that need a multi-cycle execution unit
    localparam logic [4:0] OP_MUL_INT     = 5'b00010;
    localparam logic [4:0] OP_MUL_INT_ALT = 5'b10010;
    localparam logic [4:0] OP_DIV_INT     = 5'b00011;
    localparam logic [4:0] OP_DIV_FLOAT   = 5'b00111;
    localparam logic [4:0] OP_DIV_INT_U   = 5'b10011;

    // Unit indices; also the bit positions in unit_start / unit_done
    localparam int NUM_UNITS = 4;
    localparam int UNIT_MUL  = 0;
    localparam int UNIT_DIV  = 1;
    localparam int UNIT_FDIV = 2;
    localparam int UNIT_DIVU = 3;

    // Sequencer FSM encoding
    localparam int                 STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] S_RESP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/calc_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_decode
// Purpose  : Combinational opcode decode. Maps a button_cclt opcode onto a
//            one-hot execution-unit select, or flags it as a single-cycle
//            opcode handled outside the sequencer.
// Ports    : i_op      - 5-bit opcode
//            o_unit_oh - one-hot unit select (all zero for bypass)
//            o_bypass  - opcode is not handled by any execution unit
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_decode
    import calc_pkg::*;
(
    input  logic [4:0]           i_op,
    output logic [NUM_UNITS-1:0] o_unit_oh,
    output logic                 o_bypass
);

    always_comb begin
        o_unit_oh = '0;
        o_bypass  = 1'b0;
        case (i_op)
            OP_MUL_INT,
            OP_MUL_INT_ALT: o_unit_oh[UNIT_MUL]  = 1'b1;
            OP_DIV_INT:     o_unit_oh[UNIT_DIV]  = 1'b1;
            OP_DIV_FLOAT:   o_unit_oh[UNIT_FDIV] = 1'b1;
            OP_DIV_INT_U:   o_unit_oh[UNIT_DIVU] = 1'b1;
            default:        o_bypass             = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Purpose  : Accepts one calculator operation at a time, issues a start pulse
//            to the matching multi-cycle unit, waits for its done pulse (with
//            a timeout) and returns a one-cycle response. Single-cycle
//            opcodes are acknowledged immediately as bypass.
// Ports    : clk, rst                      - clock, sync active-high reset
//            req_valid/req_ready/req_op/
//            req_a/req_b                   - request handshake and operands
//            unit_start/unit_a/unit_b      - unit start pulse and operands
//            unit_done/unit_result/unit_err- unit completion interface
//            res_valid/res_data/res_err/
//            res_timeout/res_bypass        - one-cycle response
//            last_result                   - last non-bypass result
//            busy                          - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  unit_start,
    output logic [63:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [3:0]  unit_done,
    input  logic [63:0] unit_result,
    input  logic        unit_err,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic        res_err,
    output logic        res_timeout,
    output logic        res_bypass,
    output logic [63:0] last_result,
    output logic        busy
);
    import calc_pkg::*;

    // Counter value seen in the last WAIT cycle before the abort: the
    // increment out of that cycle would make the count reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next_state;
    logic [NUM_UNITS-1:0] r_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic [63:0]          r_a;
    logic [31:0]          r_b;
    logic [63:0]          r_res_data;
    logic                 r_res_err;
    logic                 r_res_timeout;
    logic                 r_res_bypass;
    logic [63:0]          r_last_result;

    logic [NUM_UNITS-1:0] w_dec_unit;
    logic                 w_dec_bypass;
    logic                 w_accept;
    logic                 w_done_hit;
    logic                 w_timeout;

    calc_op_decode u_decode (
        .i_op      (req_op),
        .o_unit_oh (w_dec_unit),
        .o_bypass  (w_dec_bypass)
    );

    assign w_accept   = req_valid && (r_state == S_IDLE);
    // Only the unit that was started can complete the operation
    assign w_done_hit = |(unit_done & r_sel);
    assign w_timeout  = (r_cnt == c_cnt_last);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_dec_bypass ? S_RESP : S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_done_hit || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        unit_start = (r_state == S_ISSUE) ? r_sel : '0;
        res_valid  = (r_state == S_RESP);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel         <= '0;
            r_cnt         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_res_data    <= '0;
            r_res_err     <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_bypass  <= 1'b0;
            r_last_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Operands only change here, so they stay stable for the
                    // whole ISSUE..RESP window.
                    if (w_accept) begin
                        r_sel <= w_dec_unit;
                        r_a   <= req_a;
                        r_b   <= req_b;
                        if (w_dec_bypass) begin
                            r_res_data    <= '0;
                            r_res_err     <= 1'b0;
                            r_res_timeout <= 1'b0;
                            r_res_bypass  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // Done takes priority over a simultaneous timeout
                    if (w_done_hit) begin
                        r_res_data    <= unit_result;
                        r_res_err     <= unit_err;
                        r_res_timeout <= 1'b0;
                        r_res_bypass  <= 1'b0;
                        r_last_result <= unit_result;
                    end else if (w_timeout) begin
                        r_res_data    <= '0;
                        r_res_err     <= 1'b1;
                        r_res_timeout <= 1'b1;
                        r_res_bypass  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign unit_a      = r_a;
    assign unit_b      = r_b;
    assign res_data    = r_res_data;
    assign res_err     = r_res_err;
    assign res_timeout = r_res_timeout;
    assign res_bypass  = r_res_bypass;
    assign last_result = r_last_result;

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_sequencer
// Purpose  : Self-checking bench for calc_op_sequencer. A cycle-timeline
//            model (accept cycle, start at accept+1, response one cycle
//            after the selected done or after the WAIT window) predicts
//            every output; directed scenarios pin the model with literal
//            values, then a randomized phase with a unit emulator runs.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_op_sequencer;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [63:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  unit_start;
    logic [63:0] unit_a;
    logic [31:0] unit_b;
    logic [3:0]  unit_done;
    logic [63:0] unit_result;
    logic        unit_err;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_err;
    logic        res_timeout;
    logic        res_bypass;
    logic [63:0] last_result;
    logic        busy;

    calc_op_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result), .unit_err(unit_err),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .res_timeout(res_timeout), .res_bypass(res_bypass),
        .last_result(last_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit auto_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unit_of(input logic [4:0] op);
        if (op == 5'b00010 || op == 5'b10010) return 0;
        if (op == 5'b00011) return 1;
        if (op == 5'b00111) return 2;
        if (op == 5'b10011) return 3;
        return -1;
    endfunction

    // ---------------------------------------------------- timeline model
    bit          m_active = 1'b0, m_byp = 1'b0, m_err = 1'b0, m_to = 1'b0;
    bit          m_after_rst = 1'b0;
    int          m_t = 0, m_unit = 0, m_resp = -1;
    logic [63:0] m_a = '0, m_data = '0, m_last = '0;
    logic [31:0] m_b = '0;

    // observations for the literal checks
    int          obs_n_valid = 0, obs_cyc = -1, obs_n_start = 0, obs_start_cyc = -1;
    logic [63:0] obs_data = '0;
    logic        obs_err = 1'b0, obs_to = 1'b0, obs_byp = 1'b0;
    logic [3:0]  obs_start_val = '0;

    always @(negedge clk) begin : p_cmp
        int         c;
        bit         ev;
        logic [3:0] es;
        c  = cyc;
        ev = m_active && (c == m_resp);
        es = (m_active && !m_byp && c == m_t + 1) ? 4'(1 << m_unit) : 4'b0;
        if (ev && !m_byp && !m_to) m_last = m_data;
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(!m_active));
            check("busy", 64'(busy), 64'(m_active));
            check("unit_start", 64'(unit_start), 64'(es));
            check("res_valid", 64'(res_valid), 64'(ev));
            check("last_result", last_result, m_last);
            if (ev) begin
                check("res_data", res_data, m_data);
                check("res_err", 64'(res_err), 64'(m_err));
                check("res_timeout", 64'(res_timeout), 64'(m_to));
                check("res_bypass", 64'(res_bypass), 64'(m_byp));
            end
            if (m_active && !m_byp) begin
                check("unit_a", unit_a, m_a);
                check("unit_b", 64'(unit_b), 64'(m_b));
            end
            if (m_after_rst) begin
                check("rst_unit_a", unit_a, 64'd0);
                check("rst_unit_b", 64'(unit_b), 64'd0);
                check("rst_res", {res_data[59:0], res_err, res_timeout, res_bypass, res_valid}, 64'd0);
            end
        end
        if (res_valid) begin
            obs_n_valid++; obs_cyc = c; obs_data = res_data;
            obs_err = res_err; obs_to = res_timeout; obs_byp = res_bypass;
        end
        if (unit_start != 4'b0) begin
            obs_n_start++; obs_start_cyc = c; obs_start_val = unit_start;
        end
        // advance the model with this cycle's inputs
        if (rst) begin
            m_active = 1'b0; m_last = '0; m_after_rst = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            if (m_active && c == m_resp) begin
                m_active = 1'b0;
            end else if (m_active && !m_byp && m_resp < 0 && c >= m_t + 2) begin
                if (unit_done[m_unit]) begin
                    m_resp = c + 1; m_data = unit_result; m_err = unit_err; m_to = 1'b0;
                end else if (c == m_t + 1 + TO) begin
                    m_resp = c + 1; m_data = '0; m_err = 1'b1; m_to = 1'b1;
                end
            end else if (!m_active && req_valid) begin
                m_active = 1'b1; m_t = c; m_unit = unit_of(req_op);
                m_a = req_a; m_b = req_b;
                m_byp = (m_unit < 0);
                if (m_byp) begin
                    m_resp = c + 1; m_data = '0; m_err = 1'b0; m_to = 1'b0;
                end else begin
                    m_resp = -1;
                end
            end
        end
        cyc = cyc + 1;
    end

    // ------------------------------------------------------- driving
    int         em_cnt = 0;
    logic [3:0] em_bit = '0;

    task automatic tick();
        logic [4:0] ops [6];
        ops[0] = 5'b00010; ops[1] = 5'b10010; ops[2] = 5'b00011;
        ops[3] = 5'b00111; ops[4] = 5'b10011; ops[5] = 5'($urandom);
        @(posedge clk);
        #1;
        unit_done   = '0;
        rst         = 1'b0;
        unit_err    = 1'b0;
        unit_result = {$urandom, $urandom};
        if (auto_mode) begin
            if (unit_start != 4'b0) begin
                em_bit = unit_start; em_cnt = $urandom_range(1, 70);
            end else if (em_cnt > 0) begin
                em_cnt--;
                if (em_cnt == 0) unit_done = em_bit;
            end
            if ($urandom_range(0, 15) == 0) unit_done = unit_done | 4'($urandom);
            unit_err  = ($urandom_range(0, 3) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_op    = ops[$urandom_range(0, 5)];
            req_a     = {$urandom, $urandom};
            req_b     = $urandom;
            rst       = ($urandom_range(0, 399) == 0);
            if (rst) em_cnt = 0;
        end
    endtask

    task automatic do_req(input logic [4:0] op, input logic [63:0] a,
                          input logic [31:0] b, output int t);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        t = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check("wait_idle_bound", 64'(req_ready), 64'd1);
    endtask

    initial begin : p_main
        int          t, t1, nv, ns;
        logic [63:0] last_ok;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        unit_done = '0; unit_result = '0; unit_err = 1'b0;
        repeat (3) begin
            tick();
            rst = 1'b1;
        end
        tick();
        chk_en = 1'b1;
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_last", last_result, 64'd0);

        // div_int, done 5 cycles after start
        do_req(5'b00011, 64'd100, 32'd7, t);
        repeat (5) tick();
        unit_done = 4'b0010; unit_result = {32'd14, 32'd2};
        repeat (2) tick();
        check("divint_start_cyc", 64'(obs_start_cyc), 64'(t + 1));
        check("divint_start_val", 64'(obs_start_val), 64'h2);
        check("divint_resp_cyc", 64'(obs_cyc), 64'(t + 7));
        check("divint_data", obs_data, 64'h0000000E_00000002);
        check("divint_last", last_result, 64'h0000000E_00000002);
        wait_idle();

        // bypass opcode
        ns = obs_n_start;
        do_req(5'b01000, 64'hDEAD, 32'hBEEF, t);
        repeat (2) tick();
        check("byp_resp_cyc", 64'(obs_cyc), 64'(t + 1));
        check("byp_flag", {obs_data[62:0], obs_byp}, 64'd1);
        check("byp_no_start", 64'(obs_n_start), 64'(ns));
        check("byp_last", last_result, 64'h0000000E_00000002);
        wait_idle();

        // mul_int that never completes
        do_req(5'b00010, 64'h1234, 32'h5678, t);
        repeat (TO + 2) tick();
        check("to_resp_cyc", 64'(obs_cyc), 64'(t + TO + 2));
        check("to_flags", {obs_data[61:0], obs_err, obs_to}, 64'd3);
        check("to_last", last_result, 64'h0000000E_00000002);
        wait_idle();

        // div_float with stray done[0], then done[2] with error
        do_req(5'b00111, 64'h77, 32'h3, t);
        tick(); unit_done = 4'b0001;
        tick(); tick(); tick();
        unit_done = 4'b0100; unit_err = 1'b1; unit_result = 64'hABCD;
        repeat (2) tick();
        check("fdiv_resp_cyc", 64'(obs_cyc), 64'(t + 6));
        check("fdiv_err", {obs_err, obs_to}, 64'b10);
        check("fdiv_last", last_result, 64'hABCD);
        wait_idle();

        // done arrives in the last WAIT cycle: done wins over timeout
        do_req(5'b10010, 64'h5, 32'h6, t);
        repeat (TO) tick();
        unit_done = 4'b0001; unit_result = 64'h600D;
        repeat (2) tick();
        check("tie_resp_cyc", 64'(obs_cyc), 64'(t + TO + 2));
        check("tie_flags", {obs_err, obs_to}, 64'b00);
        check("tie_data", obs_data, 64'h600D);
        wait_idle();

        // reset two cycles into WAIT, then a late done
        last_ok = last_result;
        nv = obs_n_valid;
        do_req(5'b00011, 64'h99, 32'h11, t);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        unit_done = 4'b0010;
        repeat (4) tick();
        check("rst_mid_no_valid", 64'(obs_n_valid), 64'(nv));
        check("rst_mid_last", last_result, 64'd0);
        last_ok = last_result;

        // back-to-back requests with req_valid held high
        req_valid = 1'b1; req_op = 5'b00011; req_a = 64'hA1; req_b = 32'hB1;
        t1 = cyc;
        tick();
        req_op = 5'b10011; req_a = 64'hA2; req_b = 32'hB2;
        repeat (3) tick();
        unit_done = 4'b0010; unit_result = 64'h1111;
        repeat (3) tick();
        req_valid = 1'b0;
        tick();
        check("b2b_second_start_cyc", 64'(obs_start_cyc), 64'(t1 + 7));
        check("b2b_second_start_val", 64'(obs_start_val), 64'h8);
        check("b2b_unit_a", unit_a, 64'hA2);
        tick(); unit_done = 4'b1000; unit_result = 64'h2222;
        wait_idle();

        // randomized phase
        auto_mode = 1'b1;
        repeat (4000) tick();
        auto_mode = 1'b0;
        req_valid = 1'b0;
        tick();
        wait_idle();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
